// File: rtl/hrd_perf_counters.sv
// Bank of CNT_NUM performance counters (cycle, instret, events) with a 32-bit
// read/write window, sticky overflow flags and a registered overflow interrupt.
module hrd_perf_counters #(
  parameter int CNT_NUM   = 3,
  parameter int CNT_WIDTH = 64,
  parameter int INC_WIDTH = 2
) (
  input  logic                           s_clk_i,
  input  logic                           s_rst_i,
  input  logic [CNT_NUM*INC_WIDTH-1:0]   s_inc_i,
  input  logic [CNT_NUM-1:0]             s_inhibit_i,
  input  logic                           s_wen_i,
  input  logic [4:0]                     s_widx_i,
  input  logic                           s_whi_i,
  input  logic [31:0]                    s_wdata_i,
  input  logic                           s_ren_i,
  input  logic [4:0]                     s_ridx_i,
  input  logic                           s_rhi_i,
  output logic [31:0]                    s_rdata_o,
  output logic                           s_rvalid_o,
  input  logic [CNT_NUM-1:0]             s_ovf_en_i,
  input  logic [CNT_NUM-1:0]             s_ovf_clr_i,
  output logic [CNT_NUM-1:0]             s_ovf_o,
  output logic                           s_irq_o
);

  localparam int HI_WIDTH = CNT_WIDTH - 32;

  logic [CNT_WIDTH-1:0] cnt_q [CNT_NUM];
  logic [CNT_WIDTH:0]   sum   [CNT_NUM];
  logic [CNT_NUM-1:0]   wr_hit;
  logic [CNT_NUM-1:0]   ovf_set;
  logic [CNT_NUM-1:0]   ovf_q;
  logic                 irq_q;
  logic                 rvalid_q;
  logic [31:0]          rdata_q;
  logic [31:0]          rd_sel;

  // Out-of-range write indices match no counter, so they fall away naturally.
  always_comb begin
    for (int k = 0; k < CNT_NUM; k++) begin
      wr_hit[k]  = s_wen_i && (s_widx_i == 5'(k));
      sum[k]     = {1'b0, cnt_q[k]} + (CNT_WIDTH+1)'(s_inc_i[k*INC_WIDTH +: INC_WIDTH]);
      ovf_set[k] = !wr_hit[k] && !s_inhibit_i[k] && sum[k][CNT_WIDTH];
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < CNT_NUM; k++) begin
      if (s_ridx_i == 5'(k)) begin
        rd_sel = s_rhi_i ? 32'(cnt_q[k][CNT_WIDTH-1:32]) : cnt_q[k][31:0];
      end
    end
  end

  always_ff @(posedge s_clk_i) begin
    for (int k = 0; k < CNT_NUM; k++) begin
      if (s_rst_i) begin
        cnt_q[k] <= '0;
      end else if (wr_hit[k]) begin
        if (s_whi_i) begin
          cnt_q[k][CNT_WIDTH-1:32] <= s_wdata_i[HI_WIDTH-1:0];
        end else begin
          cnt_q[k][31:0] <= s_wdata_i;
        end
      end else if (!s_inhibit_i[k]) begin
        cnt_q[k] <= sum[k][CNT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) begin
      ovf_q    <= '0;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ovf_q    <= ovf_set | (ovf_q & ~s_ovf_clr_i);
      irq_q    <= |(ovf_q & s_ovf_en_i);
      rvalid_q <= s_ren_i;
      if (s_ren_i) begin
        rdata_q <= rd_sel;
      end
    end
  end

  // Gating keeps outputs quiet for the whole reset window, including a read
  // that was captured on the edge just before reset rose.
  assign s_rdata_o  = s_rst_i ? 32'd0 : rdata_q;
  assign s_rvalid_o = rvalid_q & ~s_rst_i;
  assign s_ovf_o    = s_rst_i ? '0 : ovf_q;
  assign s_irq_o    = irq_q & ~s_rst_i;

endmodule

// File: doc/hrd_perf_counters.md
HRD_PERF_COUNTERS -- requirements
Module: hrd_perf_counters

Interface
REQ-001 SHALL provide parameter CNT_NUM, default 3, number of counters; range 2..32; index 0 = cycle, 1 = instret, 2.. = event counters.
REQ-002 SHALL provide parameter CNT_WIDTH, default 64, counter width in bits; range 33..64.
REQ-003 SHALL provide parameter INC_WIDTH, default 2, width of each per-counter increment field.
REQ-004 SHALL have port s_clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port s_rst_i, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port s_inc_i, input, CNT_NUM*INC_WIDTH, unsigned increment for counter k in bits [k*INC_WIDTH +: INC_WIDTH].
REQ-007 SHALL have port s_inhibit_i, input, CNT_NUM, per-counter count inhibit (mcountinhibit image).
REQ-008 SHALL have ports s_wen_i (input, 1, write strobe), s_widx_i (input, 5, counter index), s_whi_i (input, 1, 1 = upper half), s_wdata_i (input, 32, write data).
REQ-009 SHALL have ports s_ren_i (input, 1, read strobe), s_ridx_i (input, 5), s_rhi_i (input, 1), s_rdata_o (output, 32, read data), s_rvalid_o (output, 1, read data valid).
REQ-010 SHALL have ports s_ovf_en_i (input, CNT_NUM, overflow interrupt enable), s_ovf_clr_i (input, CNT_NUM, sticky overflow clear), s_ovf_o (output, CNT_NUM, sticky overflow flags), s_irq_o (output, 1, overflow interrupt request).

Function
REQ-011 Counter k SHALL add zero-extended s_inc_i field k each cycle when s_inhibit_i[k]=0 and no write targets k; result modulo 2^CNT_WIDTH.
REQ-012 Counter k SHALL hold its value when s_inhibit_i[k]=1.
REQ-013 A write with s_widx_i<CNT_NUM SHALL replace the addressed half: low = bits [31:0]; high = bits [CNT_WIDTH-1:32], taken from s_wdata_i[CNT_WIDTH-33:0] with excess bits discarded; the other half holds its pre-write value.
REQ-014 A write SHALL take precedence over increment: the written counter does not increment in the write cycle, and no overflow is generated for it.
REQ-015 Writes with s_widx_i>=CNT_NUM SHALL be ignored.
REQ-016 Reads SHALL have fixed latency 1: s_rvalid_o=1 exactly one cycle after s_ren_i=1, otherwise 0; no stall or backpressure.
REQ-017 s_rdata_o SHALL return the addressed half of the counter value at the s_ren_i edge (pre-update value); the high half is zero-extended to 32 bits; index>=CNT_NUM returns 0.
REQ-018 s_rdata_o SHALL hold its last value while s_rvalid_o=0.
REQ-019 s_ovf_o[k] SHALL be set in the cycle counter k wraps (old + inc >= 2^CNT_WIDTH) and SHALL remain set until s_ovf_clr_i[k]=1.
REQ-020 When set and clear hit the same bit in one cycle, set SHALL win.
REQ-021 s_irq_o SHALL be registered: the OR over k of (s_ovf_o[k] AND s_ovf_en_i[k]), delayed one cycle.
REQ-022 Read and write of the same counter in the same cycle SHALL return the pre-write value; the next read returns the written value.
REQ-023 Increment adders SHALL be CNT_WIDTH+1 bits wide; the carry-out is the overflow source; no pipelining of the carry between halves.

Reset
REQ-024 While s_rst_i=1: all counters 0, s_ovf_o=0, s_irq_o=0, s_rvalid_o=0, s_rdata_o=0; writes and increments in that cycle are discarded.
REQ-025 A read issued in the cycle before reset asserts SHALL produce s_rvalid_o=0 during reset; pending read data is dropped.
REQ-026 The first increment SHALL occur at the first edge with s_rst_i=0.

Verification
REQ-027 Reset, then 10 cycles with s_inc_i[counter 0]=1, others 0, no inhibit -> read idx0 low returns 10; idx0 high returns 0; s_rvalid_o pulses one cycle after each s_ren_i.
REQ-028 Write idx1 low = 0xFFFF_FFFF, then inc=1 for one cycle -> low reads 0, high reads 1 (carry across halves in the same cycle); s_ovf_o[1]=0.
REQ-029 Write idx2 high=0xFFFF_FFFF and low=0xFFFF_FFFE, s_ovf_en_i[2]=1, inc=3 -> counter reads 1, s_ovf_o[2]=1 next cycle, s_irq_o=1 one cycle later; s_ovf_clr_i[2] pulse -> both flags drop.
REQ-030 Same-cycle write idx0 low=0x55 with inc=1 and s_ren_i idx0 -> returned data is the pre-write value; the following read returns 0x55, not 0x56.
REQ-031 s_inhibit_i[1]=1 for 5 cycles with inc=2 -> idx1 unchanged; write idx=31 with CNT_NUM=3 -> no state change, and a read of idx31 returns 0.
REQ-032 CNT_WIDTH=40: write high=0xFFFF_FFFF -> high reads 0x0000_00FF; assert s_rst_i mid-count -> all reads return 0 and s_ovf_o=0.
